mmcm_drp_reconfig_ctrl: RTL and testbench
=========================================

Name: mmcm_drp_reconfig_ctrl

Overview:
- Run-time sequencer for the Arty-A7 MMCME2_ADV. It switches the sysclk output (CLKOUT1) between the 33.3 MHz profile (divide 30) and the 20 MHz profile (divide 50) through the DRP port.
- Sequence: hold MMCM in reset, read-modify-write the two CLKOUT1 DRP registers, release reset, wait for LOCKED.
- Sits beside the MMCM wrapper in the Arty7 clocking top; DCLK is board_clk_i (100 MHz).

Parameters:
- Sysclk33M, 1'b1, profile reported by cur_sel_o after reset (1 = divide 30, 0 = divide 50).
- RstHold, 16, cycles mmcm_rst_o is held high before the first DRP access (minimum 1).
- DrdyTimeout, 64, cycles allowed from den_o to drdy_i.
- LockTimeout, 65536, cycles allowed from reset release to locked_i high.

Ports:
- board_clk_i  in  1  clock; also used as the MMCM DCLK.
- RESETn_i  in  1  asynchronous active-low reset.
- req_i  in  1  start a reconfiguration; sampled only in IDLE.
- sel_i  in  1  target profile, sampled with req_i (1 = divide 30, 0 = divide 50).
- busy_o  out  1  high from the accept cycle until DONE/ERR exit.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky error flag; cleared on next accepted req_i.
- err_code_o  out  2  00 none, 01 DRDY timeout, 10 lock timeout.
- cur_sel_o  out  1  profile last successfully programmed.
- lock_lost_o  out  1  sticky; set when locked_i falls in IDLE; cleared on accepted req_i.
- mmcm_rst_o  out  1  OR'd with ~RESETn_i into MMCM RST.
- daddr_o  out  7  DRP address.
- di_o  out  16  DRP write data.
- den_o  out  1  DRP enable, single-cycle pulse.
- dwe_o  out  1  DRP write enable, asserted only together with den_o.
- do_i  in  16  DRP read data, valid when drdy_i is high.
- drdy_i  in  1  DRP ready.
- locked_i  in  1  MMCM LOCKED, synchronous to board_clk_i.

Behaviour:
- Reset values:
  - busy_o, done_o, err_o, lock_lost_o, mmcm_rst_o, den_o, dwe_o = 0.
  - err_code_o = 00; daddr_o = 0; di_o = 0.
  - cur_sel_o = Sysclk33M; FSM = IDLE.
- Register table, indexed by idx 0..1:
  - idx0: addr 0x08 (ClkReg1), keep-mask 0xF000. Data 0x03CF for sel = 1 (high = low = 15); 0x0659 for sel = 0 (high = low = 25).
  - idx1: addr 0x09 (ClkReg2), keep-mask 0xFC00, data 0x0000 for both profiles.
- FSM states:
  - IDLE: on req_i, latch sel_i into tgt, clear err_o/err_code_o/lock_lost_o, set busy_o and mmcm_rst_o, load counter = RstHold, go to RST_HOLD.
  - RST_HOLD: count down; at 0, set idx = 0 and go to RD_REQ.
  - RD_REQ: assert den_o for one cycle with dwe_o = 0, daddr_o = addr[idx]; load counter = DrdyTimeout; go to RD_WAIT.
  - RD_WAIT: on drdy_i, capture (do_i & mask) | data[tgt] into di_o and go to WR_REQ. If the counter expires, go to ERR with code 01.
  - WR_REQ: assert den_o and dwe_o for one cycle, same address; load counter; go to WR_WAIT.
  - WR_WAIT: on drdy_i, go to RD_REQ with idx+1 if idx = 0, else go to RELEASE. If the counter expires, go to ERR with code 01.
  - RELEASE: drop mmcm_rst_o, load counter = LockTimeout, go to WAIT_LOCK.
  - WAIT_LOCK: when locked_i is high, go to DONE. If the counter expires, go to ERR with code 10.
  - DONE: pulse done_o, set cur_sel_o = tgt, clear busy_o, return to IDLE.
  - ERR: set err_o, drop mmcm_rst_o, clear busy_o, return to IDLE; cur_sel_o is unchanged.
- Latency: a successful transaction takes at least RstHold + 6 + lock time cycles.
- req_i while busy is ignored (no queuing).
- req_i with sel_i equal to cur_sel_o still runs the full sequence.
- drdy_i outside RD_WAIT/WR_WAIT is ignored.
- drdy_i in the same cycle as den_o is accepted as the response.
- drdy_i on the exact cycle the counter reaches 0 counts as success (drdy_i has priority).
- Counters are $clog2(max + 1) wide and saturate at 0.
- RESETn_i asserted mid-sequence aborts immediately to reset values. The MMCM is left under its own ~RESETn_i reset.

Test Plan:
- Power-up with Sysclk33M = 1 → cur_sel_o = 1, all other outputs 0.
- req_i with sel_i = 0, DRP model returns do_i = 0xA000 then 0x1C00, locked_i raised 100 cycles after release:
  - writes: 0x08 ← 0xA659, then 0x09 ← 0x1C00.
  - mmcm_rst_o high ≥ 16 cycles; done_o pulses once; cur_sel_o = 0.
- req_i with sel_i = 1 → write 0x08 ← (do & 0xF000) | 0x03CF.
- DRP model never raises drdy_i:
  - 64 cycles after the first den_o: err_o = 1, err_code_o = 01, mmcm_rst_o = 0, cur_sel_o unchanged.
- locked_i held low → 65536 cycles after release: err_code_o = 10, no done_o.
- Extra req_i pulses during busy → no extra den_o.
- RESETn_i pulsed in WAIT_LOCK → outputs return to reset values.
- locked_i dropped in IDLE → lock_lost_o set, then cleared by the next req_i.

Source files
------------

// File: rtl/mmcm_drp_reconfig_ctrl.sv
// mmcm_drp_reconfig_ctrl
//   Run-time sequencer that retargets MMCME2_ADV CLKOUT1 between divide-30
//   (sel = 1) and divide-50 (sel = 0) through the DRP. The MMCM is held in
//   reset while the ClkReg1/ClkReg2 pair is read-modify-written, then it is
//   released and LOCKED is awaited.
// Ports
//   board_clk_i     100 MHz clock, also MMCM DCLK
//   RESETn_i        async active-low reset
//   req_i/sel_i     start request and target profile (sampled in IDLE only)
//   busy_o          sequence in progress
//   done_o          one-cycle success pulse
//   err_o/err_code_o sticky error, 01 = DRDY timeout, 10 = lock timeout
//   cur_sel_o       last successfully programmed profile
//   lock_lost_o     sticky, LOCKED fell while idle
//   mmcm_rst_o      MMCM reset request
//   daddr_o/di_o/den_o/dwe_o/do_i/drdy_i  DRP master port
//   locked_i        MMCM LOCKED (already in board_clk_i domain)
module mmcm_drp_reconfig_ctrl #(
  parameter logic Sysclk33M   = 1'b1,
  parameter int   RstHold     = 16,
  parameter int   DrdyTimeout = 64,
  parameter int   LockTimeout = 65536
) (
  input  logic        board_clk_i,
  input  logic        RESETn_i,
  input  logic        req_i,
  input  logic        sel_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        cur_sel_o,
  output logic        lock_lost_o,
  output logic        mmcm_rst_o,
  output logic [6:0]  daddr_o,
  output logic [15:0] di_o,
  output logic        den_o,
  output logic        dwe_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  input  logic        locked_i
);

  // One shared counter serves all three timed phases, sized for the longest.
  localparam int CntMax0 = (RstHold > DrdyTimeout) ? RstHold : DrdyTimeout;
  localparam int CntMax  = (CntMax0 > LockTimeout) ? CntMax0 : LockTimeout;
  localparam int CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstHoldC = CntW'(RstHold);
  localparam logic [CntW-1:0] DrdyC    = CntW'(DrdyTimeout);
  localparam logic [CntW-1:0] LockC    = CntW'(LockTimeout);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrDrdy = 2'b01;
  localparam logic [1:0] ErrLock = 2'b10;

  typedef enum logic [3:0] {
    IDLE, RST_HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT,
    RELEASE, WAIT_LOCK, DONE, ERR
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_dec;
  logic            cnt_zero;
  logic            idx_q, tgt_q;
  logic [15:0]     di_q;
  logic            err_q, cur_sel_q, lock_lost_q, locked_prev_q;
  logic [1:0]      err_code_q;
  logic            rd_phase, wr_phase, drp_ack;
  logic [6:0]      reg_addr;
  logic [15:0]     keep_mask, new_bits;

  // Register table: idx 0 = ClkReg1 (high/low time), idx 1 = ClkReg2.
  always_comb begin
    reg_addr  = idx_q ? 7'h09 : 7'h08;
    keep_mask = idx_q ? 16'hFC00 : 16'hF000;
    new_bits  = idx_q ? 16'h0000 : (tgt_q ? 16'h03CF : 16'h0659);
  end

  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_zero ? '0 : cnt_q - CntOne;
  assign rd_phase = (state_q == RD_REQ) || (state_q == RD_WAIT);
  assign wr_phase = (state_q == WR_REQ) || (state_q == WR_WAIT);
  // A response in the same cycle as den_o is accepted as well.
  assign drp_ack  = drdy_i && (rd_phase || wr_phase);

  // State register
  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; drdy_i/locked_i win over an expiring counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req_i) state_d = RST_HOLD;
      RST_HOLD:  if (cnt_q <= CntOne) state_d = RD_REQ;
      RD_REQ:    state_d = drdy_i ? WR_REQ : RD_WAIT;
      RD_WAIT:   if (drdy_i) state_d = WR_REQ;
                 else if (cnt_zero) state_d = ERR;
      WR_REQ:    if (drdy_i) state_d = idx_q ? RELEASE : RD_REQ;
                 else state_d = WR_WAIT;
      WR_WAIT:   if (drdy_i) state_d = idx_q ? RELEASE : RD_REQ;
                 else if (cnt_zero) state_d = ERR;
      RELEASE:   state_d = WAIT_LOCK;
      WAIT_LOCK: if (locked_i) state_d = DONE;
                 else if (cnt_zero) state_d = ERR;
      DONE:      state_d = IDLE;
      ERR:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o     = 1'b1;
    done_o     = 1'b0;
    mmcm_rst_o = 1'b0;
    den_o      = 1'b0;
    dwe_o      = 1'b0;
    daddr_o    = '0;
    case (state_q)
      IDLE:     busy_o = 1'b0;
      RST_HOLD: mmcm_rst_o = 1'b1;
      RD_REQ:   begin mmcm_rst_o = 1'b1; den_o = 1'b1; daddr_o = reg_addr; end
      WR_REQ:   begin mmcm_rst_o = 1'b1; den_o = 1'b1; dwe_o = 1'b1; daddr_o = reg_addr; end
      RD_WAIT,
      WR_WAIT:  begin mmcm_rst_o = 1'b1; daddr_o = reg_addr; end
      DONE:     done_o = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: counter, table index, write data and status flags
  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      cnt_q         <= '0;
      idx_q         <= 1'b0;
      tgt_q         <= Sysclk33M;
      di_q          <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ErrNone;
      cur_sel_q     <= Sysclk33M;
      lock_lost_q   <= 1'b0;
      locked_prev_q <= 1'b0;
    end else begin
      locked_prev_q <= locked_i;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            tgt_q       <= sel_i;
            err_q       <= 1'b0;
            err_code_q  <= ErrNone;
            lock_lost_q <= 1'b0;
            cnt_q       <= RstHoldC;
            idx_q       <= 1'b0;
          end else if (locked_prev_q && !locked_i) begin
            lock_lost_q <= 1'b1;
          end
        end
        RST_HOLD, RD_WAIT, WR_WAIT, WAIT_LOCK: cnt_q <= cnt_dec;
        RD_REQ, WR_REQ: cnt_q <= DrdyC;
        RELEASE:        cnt_q <= LockC;
        DONE:           cur_sel_q <= tgt_q;
        ERR:            err_q <= 1'b1;
        default: ;
      endcase
      if (drp_ack && rd_phase) di_q <= (do_i & keep_mask) | new_bits;
      if (drp_ack && wr_phase && !idx_q) idx_q <= 1'b1;
      if (state_d == ERR && state_q != ERR)
        err_code_q <= (state_q == WAIT_LOCK) ? ErrLock : ErrDrdy;
    end
  end

  assign di_o        = di_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign cur_sel_o   = cur_sel_q;
  assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// Bench for mmcm_drp_reconfig_ctrl: DRP slave + MMCM lock model, table of
// directed vectors, randomized transactions against a register-level model,
// and hand-written sequences for timeouts, reset abort and lock loss.
module tb_mmcm_drp_reconfig_ctrl;
  logic        board_clk_i = 1'b0;
  logic        RESETn_i = 1'b0;
  logic        req_i = 1'b0, sel_i = 1'b0;
  logic        busy_o, done_o, err_o, cur_sel_o, lock_lost_o, mmcm_rst_o;
  logic [1:0]  err_code_o;
  logic [6:0]  daddr_o;
  logic [15:0] di_o;
  logic        den_o, dwe_o;
  logic [15:0] do_i = 16'h0;
  logic        drdy_i = 1'b0, locked_i = 1'b0;

  mmcm_drp_reconfig_ctrl dut (
    .board_clk_i(board_clk_i), .RESETn_i(RESETn_i), .req_i(req_i), .sel_i(sel_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .cur_sel_o(cur_sel_o), .lock_lost_o(lock_lost_o), .mmcm_rst_o(mmcm_rst_o),
    .daddr_o(daddr_o), .di_o(di_o), .den_o(den_o), .dwe_o(dwe_o),
    .do_i(do_i), .drdy_i(drdy_i), .locked_i(locked_i));

  initial forever #5 board_clk_i = ~board_clk_i;

  int n_vec = 0, n_err = 0;

  // environment controls (written by the test, read by the models)
  logic [15:0] rd8 = 16'h0, rd9 = 16'h0;
  int drp_lat = 1, lock_delay = 10;
  bit never_rdy = 1'b0, lock_never = 1'b0, lock_drop = 1'b0;

  // observations (written by the models, read by the test)
  int cyc = 0, den_cnt = 0, done_cnt = 0, wr_cnt = 0;
  int rst_run = 0, last_rst_run = 0, last_den_cyc = 0, rel_cyc = 0;
  logic [6:0]  wr_a [64];
  logic [15:0] wr_d [64];
  logic exp_cur;

  typedef struct {
    logic        sel;
    logic [15:0] r8, r9;
    int          lat, ldel;
    logic [15:0] w8, w9;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: new register value after read-modify-write.
  function automatic logic [15:0] exp_w(input int idx, input logic s, input logic [15:0] rd);
    if (idx == 0) return (rd & 16'hF000) | (s ? 16'h03CF : 16'h0659);
    return rd & 16'hFC00;
  endfunction

  // DRP slave, MMCM lock behaviour and event monitor, all on the falling edge.
  initial begin
    int pend, lctr;
    pend = 0; lctr = 0;
    forever begin
      @(negedge board_clk_i);
      cyc++;
      drdy_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) drdy_i = 1'b1;
      end
      if (den_o) begin
        den_cnt++;
        last_den_cyc = cyc;
        if (dwe_o) begin
          wr_a[wr_cnt % 64] = daddr_o;
          wr_d[wr_cnt % 64] = di_o;
          wr_cnt++;
        end else begin
          do_i = (daddr_o == 7'h09) ? rd9 : rd8;
        end
        if (!never_rdy) begin
          if (drp_lat == 0) drdy_i = 1'b1;
          else pend = drp_lat;
        end
      end
      if (mmcm_rst_o) begin
        locked_i = 1'b0; lctr = 0;
      end else if (lock_never || lock_drop) begin
        locked_i = 1'b0;
      end else if (!locked_i) begin
        lctr++;
        if (lctr >= lock_delay) locked_i = 1'b1;
      end
      if (done_o) done_cnt++;
      if (mmcm_rst_o) rst_run++;
      else begin
        if (rst_run > 0) begin last_rst_run = rst_run; rel_cyc = cyc; end
        rst_run = 0;
      end
    end
  end

  // Issue one request (called at a falling edge) and wait for busy to drop.
  task automatic txn(input logic s, input int xreq, output int endc);
    int n, x;
    x = xreq;
    req_i = 1'b1; sel_i = s;
    @(negedge board_clk_i);
    req_i = 1'b0; sel_i = ~s;
    chk("accept", {busy_o, err_o, lock_lost_o}, 3'b100);
    n = 0;
    while (busy_o && n < 70000) begin
      if (x > 0 && n % 5 == 2) begin req_i = 1'b1; x--; end
      else req_i = 1'b0;
      @(negedge board_clk_i);
      n++;
    end
    req_i = 1'b0;
    endc = cyc;
    chk("busy_drop", busy_o, 1'b0);
  endtask

  task automatic apply(input string tag, input logic s, input logic [15:0] r8, input logic [15:0] r9,
                       input int lat, input int ldel, input logic [15:0] w8, input logic [15:0] w9,
                       input int xreq);
    int den0, done0, wr0, endc;
    rd8 = r8; rd9 = r9; drp_lat = lat; lock_delay = ldel;
    den0 = den_cnt; done0 = done_cnt; wr0 = wr_cnt;
    txn(s, xreq, endc);
    chk({tag, "_nwr"}, wr_cnt - wr0, 2);
    chk({tag, "_a8"}, wr_a[wr0 % 64], 7'h08);
    chk({tag, "_w8"}, wr_d[wr0 % 64], w8);
    chk({tag, "_a9"}, wr_a[(wr0 + 1) % 64], 7'h09);
    chk({tag, "_w9"}, wr_d[(wr0 + 1) % 64], w9);
    chk({tag, "_nden"}, den_cnt - den0, 4);
    chk({tag, "_ndone"}, done_cnt - done0, 1);
    chk({tag, "_cur"}, cur_sel_o, s);
    chk({tag, "_err"}, {err_o, err_code_o}, 3'b000);
    chk({tag, "_rsthold"}, last_rst_run >= 16, 1'b1);
    exp_cur = s;
  endtask

  task automatic wait_lock();
    int n;
    n = 0;
    while (!locked_i && n < 2000) begin @(negedge board_clk_i); n++; end
    chk("relock", locked_i, 1'b1);
  endtask

  initial begin
    vec_t vt[5];
    int endc, den0, done0, wr0, n;
    logic s;
    logic [15:0] r8, r9;
    vt[0] = '{1'b0, 16'hA000, 16'h1C00, 2, 100, 16'hA659, 16'h1C00};
    vt[1] = '{1'b1, 16'hA659, 16'h1C00, 0, 5,   16'hA3CF, 16'h1C00};
    vt[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 64, 7,  16'hF3CF, 16'hFC00};
    vt[3] = '{1'b0, 16'h0FFF, 16'h03FF, 1, 20,  16'h0659, 16'h0000};
    vt[4] = '{1'b0, 16'h1234, 16'h5678, 3, 1,   16'h1659, 16'h5400};
    exp_cur = 1'b1;

    // power-up
    repeat (3) @(negedge board_clk_i);
    chk("rst_ctrl", {busy_o, done_o, err_o, err_code_o, cur_sel_o, lock_lost_o, mmcm_rst_o, den_o, dwe_o}, 10'h010);
    chk("rst_drp", {daddr_o, di_o}, 23'h0);
    RESETn_i = 1'b1;
    repeat (20) @(negedge board_clk_i);
    chk("idle_ctrl", {busy_o, done_o, err_o, err_code_o, cur_sel_o, lock_lost_o, mmcm_rst_o, den_o, dwe_o}, 10'h010);

    // directed table
    for (int i = 0; i < 5; i++)
      apply($sformatf("vec%0d", i), vt[i].sel, vt[i].r8, vt[i].r9, vt[i].lat, vt[i].ldel,
            vt[i].w8, vt[i].w9, 0);

    // randomized transactions
    for (int i = 0; i < 20; i++) begin
      s  = 1'($urandom_range(0, 1));
      r8 = 16'($urandom);
      r9 = 16'($urandom);
      apply($sformatf("rnd%0d", i), s, r8, r9, $urandom_range(0, 8), $urandom_range(1, 40),
            exp_w(0, s, r8), exp_w(1, s, r9), 0);
    end

    // DRP never answers
    never_rdy = 1'b1;
    den0 = den_cnt; done0 = done_cnt;
    txn(~exp_cur, 0, endc);
    chk("drdy_to_flags", {err_o, err_code_o, mmcm_rst_o, cur_sel_o}, {1'b1, 2'b01, 1'b0, exp_cur});
    chk("drdy_to_nden", den_cnt - den0, 1);
    chk("drdy_to_ndone", done_cnt - done0, 0);
    chk("drdy_to_window", (endc - last_den_cyc >= 64) && (endc - last_den_cyc <= 72), 1'b1);
    never_rdy = 1'b0;
    lock_delay = 10;
    wait_lock();

    // lock lost while idle, sticky, cleared by the next accepted request
    lock_drop = 1'b1;
    repeat (3) @(negedge board_clk_i);
    chk("lock_lost_set", lock_lost_o, 1'b1);
    lock_drop = 1'b0;
    repeat (3) @(negedge board_clk_i);
    chk("lock_lost_sticky", {locked_i, lock_lost_o}, 2'b11);
    apply("ll_clr", 1'b1, 16'h5555, 16'hAAAA, 1, 4, 16'h53CF, 16'hA800, 0);
    chk("lock_lost_after", lock_lost_o, 1'b0);

    // extra requests while busy must not start anything
    apply("xreq", 1'b0, 16'h8000, 16'h0400, 2, 30, 16'h8659, 16'h0400, 3);

    // reset while waiting for lock
    lock_delay = 500;
    req_i = 1'b1; sel_i = 1'b1;
    @(negedge board_clk_i);
    req_i = 1'b0;
    n = 0;
    while (mmcm_rst_o && n < 1000) begin @(negedge board_clk_i); n++; end
    repeat (10) @(negedge board_clk_i);
    chk("wl_busy", {busy_o, mmcm_rst_o}, 2'b10);
    RESETn_i = 1'b0;
    #1;
    chk("wl_rst_ctrl", {busy_o, done_o, err_o, err_code_o, cur_sel_o, lock_lost_o, mmcm_rst_o, den_o, dwe_o}, 10'h010);
    chk("wl_rst_drp", {daddr_o, di_o}, 23'h0);
    @(negedge board_clk_i);
    RESETn_i = 1'b1;
    exp_cur = 1'b1;
    lock_delay = 10;
    wait_lock();

    // lock never comes back
    lock_never = 1'b1;
    done0 = done_cnt; wr0 = wr_cnt;
    txn(1'b0, 0, endc);
    chk("lock_to_flags", {err_o, err_code_o, mmcm_rst_o, cur_sel_o}, {1'b1, 2'b10, 1'b0, exp_cur});
    chk("lock_to_ndone", done_cnt - done0, 0);
    chk("lock_to_nwr", wr_cnt - wr0, 2);
    chk("lock_to_window", (endc - rel_cyc >= 65536) && (endc - rel_cyc <= 65546), 1'b1);
    lock_never = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
